// File: rtl/fft8_sequencer.sv
// rtl/fft8_sequencer.sv - 8-point radix-2 DIT FFT sharing one complex butterfly across all 12 butterflies
module fft8_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag,
    output logic [2:0]       out_index,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    localparam int PW = WIDTH + 17;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem_re [8];
    logic [WIDTH-1:0] mem_im [8];

    logic [2:0] n;
    logic [1:0] s;
    logic [1:0] b;
    logic [2:0] k;
    logic       done_q;

    logic load_fire;
    logic bfly_en;
    logic unload_fire;
    logic last_bfly;

    logic [2:0] top;
    logic [2:0] bot;
    logic [1:0] tw_idx;

    logic [WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic [WIDTH-1:0] t_re, t_im;
    logic [WIDTH-1:0] mul_re, mul_im;
    logic [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;

    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    logic signed [PW-1:0] bx_re, bx_im, wx_re, wx_im;
    logic signed [PW-1:0] prod_re, prod_im;
    logic prod_unused;

    assign last_bfly = (s == 2'd2) && (b == 2'd3);

    // State register; any reset drops the frame in flight and returns to LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the handshake and strobe outputs of each phase
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        load_fire   = 1'b0;
        bfly_en     = 1'b0;
        unload_fire = 1'b0;
        case (state)
            LOAD: begin
                in_ready  = 1'b1;
                load_fire = in_valid;
                if (in_valid && (n == 3'd7)) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy    = 1'b1;
                bfly_en = 1'b1;
                if (last_bfly) begin
                    state_next = UNLOAD;
                end
            end
            UNLOAD: begin
                busy        = 1'b1;
                out_valid   = 1'b1;
                unload_fire = out_ready;
                if (out_ready && (k == 3'd7)) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Sample, stage/butterfly and bin counters plus the registered done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n      <= 3'd0;
            s      <= 2'd0;
            b      <= 2'd0;
            k      <= 3'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= unload_fire && (k == 3'd7);
            if (load_fire) begin
                n <= n + 3'd1;
            end
            if (bfly_en) begin
                b <= b + 2'd1;
                if (last_bfly) begin
                    s <= 2'd0;
                end else if (b == 2'd3) begin
                    s <= s + 2'd1;
                end
            end
            if (unload_fire) begin
                k <= k + 3'd1;
            end
        end
    end

    // Butterfly operand addresses and twiddle index; each stage span is 1<<s,
    // so the general top/bot/twiddle formulas collapse to bit rearrangements of b
    always_comb begin
        top    = 3'd0;
        bot    = 3'd0;
        tw_idx = 2'd0;
        case (s)
            2'd0: begin
                top    = {b, 1'b0};
                bot    = {b, 1'b1};
                tw_idx = 2'd0;
            end
            2'd1: begin
                top    = {b[1], 1'b0, b[0]};
                bot    = {b[1], 1'b1, b[0]};
                tw_idx = {b[0], 1'b0};
            end
            default: begin
                top    = {1'b0, b};
                bot    = {1'b1, b};
                tw_idx = b;
            end
        endcase
    end

    assign a_re = mem_re[top];
    assign a_im = mem_im[top];
    assign b_re = mem_re[bot];
    assign b_im = mem_im[bot];

    // Q1.15 twiddle for the odd indices: W1 = (c, -c), W3 = (-c, -c)
    always_comb begin
        w_re = tw_idx[1] ? -16'sd23170 : 16'sd23170;
        w_im = -16'sd23170;
    end

    assign bx_re = {{17{b_re[WIDTH-1]}}, b_re};
    assign bx_im = {{17{b_im[WIDTH-1]}}, b_im};
    assign wx_re = {{(WIDTH+1){w_re[15]}}, w_re};
    assign wx_im = {{(WIDTH+1){w_im[15]}}, w_im};

    // Exact products in PW bits; taking bits above 15 is an arithmetic shift (floor)
    assign prod_re = (bx_re * wx_re) - (bx_im * wx_im);
    assign prod_im = (bx_re * wx_im) + (bx_im * wx_re);
    assign mul_re  = prod_re[WIDTH+14:15];
    assign mul_im  = prod_im[WIDTH+14:15];
    assign prod_unused = ^{prod_re[14:0], prod_re[PW-1:WIDTH+15],
                           prod_im[14:0], prod_im[PW-1:WIDTH+15]};

    // Twiddle select: W0 passes B through, W2 (-j) is an exact swap/negate
    always_comb begin
        t_re = b_re;
        t_im = b_im;
        case (tw_idx)
            2'd0: begin
                t_re = b_re;
                t_im = b_im;
            end
            2'd2: begin
                t_re = b_im;
                t_im = '0 - b_re;
            end
            default: begin
                t_re = mul_re;
                t_im = mul_im;
            end
        endcase
    end

    assign sum_re = a_re + t_re;
    assign sum_im = a_im + t_im;
    assign dif_re = a_re - t_re;
    assign dif_im = a_im - t_im;

    // In-place working memory: bit-reversed loading, then butterfly write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else if (load_fire) begin
            mem_re[{n[0], n[1], n[2]}] <= in_real;
            mem_im[{n[0], n[1], n[2]}] <= in_imag;
        end else if (bfly_en) begin
            mem_re[top] <= sum_re;
            mem_im[top] <= sum_im;
            mem_re[bot] <= dif_re;
            mem_im[bot] <= dif_im;
        end
    end

    // Bin data is only presented while unloading so the bus idles at zero
    assign out_real  = out_valid ? mem_re[k] : '0;
    assign out_imag  = out_valid ? mem_im[k] : '0;
    assign out_index = k;
    assign done      = done_q;

endmodule

// File: tb/tb_fft8_sequencer.sv
// tb/tb_fft8_sequencer.sv - directed-vector self-checking bench for fft8_sequencer
`timescale 1ns/1ps
module tb_fft8_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic [2:0]  out_index;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int frames_done = 0;

    int xr[8];
    int xi[8];
    int er[8];
    int ei[8];

    fft8_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 8; i++) begin
            xr[i] = 0; xi[i] = 0; er[i] = 0; ei[i] = 0;
        end
    endtask

    task automatic load_frame(input string tag, input bit hold_valid);
        int guard;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_real  = 16'(xr[i]);
            in_imag  = 16'(xi[i]);
            guard = 0;
            while (!in_ready && guard < 60) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 60) check({tag, "_ready_timeout"}, 0, 1);
            @(posedge clk); #1;
        end
        if (hold_valid) begin
            in_real = 16'h1234;
            in_imag = 16'h4321;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input bit hold_valid, input bit bp);
        int lat;
        int idx;
        int guard;
        bit stalled;
        logic [15:0] h_re, h_im;
        logic [2:0]  h_idx;
        load_frame(tag, hold_valid);
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (hold_valid) check({tag, "_inrdy_compute"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency_edges"}, lat, 12);
        idx = 0;
        guard = 0;
        stalled = 1'b0;
        h_re = '0; h_im = '0; h_idx = '0;
        while (idx < 8 && guard < 200) begin
            if (bp) out_ready = (guard == 1 || guard == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            else    out_ready = 1'b1;
            if (!out_valid) check({tag, "_out_valid"}, out_valid, 1);
            if (stalled) begin
                check({tag, "_stall_re"}, $signed(out_real), $signed(h_re));
                check({tag, "_stall_im"}, $signed(out_imag), $signed(h_im));
                check({tag, "_stall_idx"}, out_index, h_idx);
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s_idx%0d", tag, idx), out_index, idx);
                check($sformatf("%s_re%0d", tag, idx), $signed(out_real), er[idx]);
                check($sformatf("%s_im%0d", tag, idx), $signed(out_imag), ei[idx]);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                h_re = out_real; h_im = out_imag; h_idx = out_index;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        if (guard >= 200) check({tag, "_unload_timeout"}, 0, 1);
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_inrdy_done"}, in_ready, 1);
        check({tag, "_ovalid_after"}, out_valid, 0);
        frames_done++;
        @(posedge clk); #1;
        check({tag, "_done_clear"}, done, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // impulse at n=0: flat spectrum
        clear_vec();
        xr[0] = 1;
        for (int i = 0; i < 8; i++) er[i] = 1;
        run_frame("impulse", 1'b0, 1'b0);

        // DC with in_valid held through COMPUTE
        clear_vec();
        for (int i = 0; i < 8; i++) xr[i] = 1000;
        er[0] = 8000;
        run_frame("dc_hold", 1'b1, 1'b0);

        // shifted impulse under output backpressure
        clear_vec();
        xr[1] = 16384;
        er = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
        ei = '{0, -11585, -16384, -11585, 0, 11585, 16384, 11585};
        run_frame("shift_bp", 1'b0, 1'b1);

        // DC sum wraps to zero in both components
        clear_vec();
        for (int i = 0; i < 8; i++) begin xr[i] = 16384; xi[i] = -16384; end
        run_frame("wrap_dc", 1'b0, 1'b0);

        // alternating sign: X[4] = 32768 wraps to -32768
        clear_vec();
        for (int i = 0; i < 8; i++) xr[i] = (i % 2 == 0) ? 4096 : -4096;
        er[4] = -32768;
        run_frame("wrap_alt", 1'b0, 1'b0);

        // x[1]=(1,1): cross terms of the complex multiply and floor rounding
        clear_vec();
        xr[1] = 1; xi[1] = 1;
        er = '{1, 1, 1, 0, -1, -1, -1, 0};
        ei = '{1, 0, -1, -2, -1, 0, 1, 2};
        run_frame("trunc", 1'b0, 1'b1);

        // reset asserted in COMPUTE cycle 5, then a clean impulse frame
        clear_vec();
        xr[0] = 1;
        for (int i = 0; i < 8; i++) er[i] = 1;
        load_frame("midrst", 1'b0);
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_out_index", out_index, 0);
        check("midrst_out_real", out_real, 0);
        check("midrst_out_imag", out_imag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("post_rst", 1'b0, 1'b0);

        check("done_pulse_count", done_seen, frames_done);
        check("frames_completed", frames_done, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
